// File: rtl/instruction_fetch_stage.sv
// Fetch stage: program counter, word-addressed instruction memory with a load port,
// and next-PC selection between reset, branch, jump, sequential advance and stall.
module instruction_fetch_stage #(
  parameter int          DEPTH    = 256,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              PCWrite,
  input  logic              Branch,
  input  logic [31:0]       BranchTarget,
  input  logic              jump,
  input  logic [31:0]       JumpTarget,
  input  logic              ProgWrite,
  input  logic [ADDR_W-1:0] ProgAddr,
  input  logic [31:0]       ProgData,
  output logic [31:0]       PC,
  output logic [31:0]       PCPlus4,
  output logic [31:0]       Instruction,
  output logic [31:0]       FetchCount
);

  logic [31:0]       mem [DEPTH];
  logic [31:0]       pc_q;
  logic [31:0]       pc_d;
  logic [31:0]       count_q;
  logic [31:0]       count_d;
  logic [ADDR_W-1:0] word_idx;
  logic              in_range;

  // Next-PC selection; a redirect is honoured even while the hazard unit stalls.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    if (Branch) begin
      pc_d    = BranchTarget;
      count_d = count_q + 32'd1;
    end else if (jump) begin
      pc_d    = JumpTarget;
      count_d = count_q + 32'd1;
    end else if (PCWrite) begin
      pc_d    = pc_q + 32'd4;
      count_d = count_q + 32'd1;
    end else begin
      pc_d    = pc_q;
      count_d = count_q;
    end
  end

  // PC and fetch counter registers; reset overrides every update.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // Program-load port; contents survive reset.
  always_ff @(posedge Clk) begin
    if (ProgWrite) begin
      mem[ProgAddr] <= ProgData;
    end
  end

  // Combinational read; addresses beyond the memory return a NOP.
  always_comb begin
    word_idx = pc_q[ADDR_W+1:2];
    in_range = ((pc_q >> (ADDR_W + 2)) == 32'd0);
    if (in_range) begin
      Instruction = mem[word_idx];
    end else begin
      Instruction = 32'h0000_0000;
    end
  end

  assign PC         = pc_q;
  assign PCPlus4    = pc_q + 32'd4;
  assign FetchCount = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: the driver queues the expected post-edge
// state of each step; an independent monitor pops and compares on the falling edge.
module tb_instruction_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        PCWrite = 1'b0;
  logic        Branch = 1'b0;
  logic [31:0] BranchTarget = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] JumpTarget = 32'd0;
  logic        ProgWrite = 1'b0;
  logic [7:0]  ProgAddr = 8'd0;
  logic [31:0] ProgData = 32'd0;
  logic [31:0] PC, PCPlus4, Instruction, FetchCount;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  instruction_fetch_stage #(.DEPTH(256), .ADDR_W(8), .RESET_PC(32'h0000_0000)) dut (
    .Clk(Clk), .Rst(Rst), .PCWrite(PCWrite), .Branch(Branch), .BranchTarget(BranchTarget),
    .jump(jump), .JumpTarget(JumpTarget), .ProgWrite(ProgWrite), .ProgAddr(ProgAddr),
    .ProgData(ProgData), .PC(PC), .PCPlus4(PCPlus4), .Instruction(Instruction),
    .FetchCount(FetchCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  // Monitor: every queued expectation is compared against the state after its edge.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".pc"},      PC,          e.pc);
      check({e.name, ".pcplus4"}, PCPlus4,     e.pc + 32'd4);
      check({e.name, ".instr"},   Instruction, e.ins);
      check({e.name, ".count"},   FetchCount,  e.cnt);
    end
  end

  task automatic step(input logic rst, input logic pcw, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt, input logic pw,
                      input logic [7:0] pa, input logic [31:0] pd,
                      input logic [31:0] e_pc, input logic [31:0] e_ins,
                      input logic [31:0] e_cnt, input string nm);
    exp_t e;
    Rst = rst; PCWrite = pcw; Branch = br; BranchTarget = bt;
    jump = jp; JumpTarget = jt; ProgWrite = pw; ProgAddr = pa; ProgData = pd;
    @(posedge Clk);
    #1;
    e.pc = e_pc; e.ins = e_ins; e.cnt = e_cnt; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic adv(input logic [31:0] e_pc, input logic [31:0] e_ins,
                     input logic [31:0] e_cnt, input string nm);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0, e_pc, e_ins, e_cnt, nm);
  endtask

  task automatic hold(input logic [31:0] e_pc, input logic [31:0] e_ins,
                      input logic [31:0] e_cnt, input string nm);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0, e_pc, e_ins, e_cnt, nm);
  endtask

  task automatic jmp(input logic [31:0] t, input logic [31:0] e_ins,
                     input logic [31:0] e_cnt, input string nm);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, t, 1'b0, 8'd0, 32'd0, t, e_ins, e_cnt, nm);
  endtask

  initial begin
    logic [31:0] w [4];
    w[0] = 32'h1111_1111; w[1] = 32'h2222_2222; w[2] = 32'h3333_3333; w[3] = 32'h4444_4444;

    // Load words 0..31 while held in reset; no expectations queued yet.
    for (int i = 0; i < 32; i++) begin
      Rst = 1'b1; ProgWrite = 1'b1; ProgAddr = 8'(i);
      ProgData = (i < 4) ? w[i] : (32'hA000_0000 + 32'(i));
      @(posedge Clk);
      #1;
    end

    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0,
         32'h0, 32'h1111_1111, 32'd0, "reset");
    adv(32'h4, 32'h2222_2222, 32'd1, "adv1");
    adv(32'h8, 32'h3333_3333, 32'd2, "adv2");
    for (int i = 0; i < 3; i++) hold(32'h8, 32'h3333_3333, 32'd2, "stall");
    adv(32'hC,  32'h4444_4444, 32'd3, "resume");
    adv(32'h10, 32'hA000_0004, 32'd4, "adv4");

    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0,
         32'h40, 32'hA000_0010, 32'd5, "branch_in_stall");
    jmp(32'h20, 32'hA000_0008, 32'd6, "jump");
    step(1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h30, 1'b0, 8'd0, 32'd0,
         32'h10, 32'hA000_0004, 32'd7, "branch_beats_jump");
    jmp(32'h0000_0400, 32'h0, 32'd8, "out_of_range");
    jmp(32'h0000_000A, 32'h3333_3333, 32'd9, "misaligned");
    jmp(32'hFFFF_FFFC, 32'h0, 32'd10, "top_of_space");
    adv(32'h0, 32'h1111_1111, 32'd11, "pc_wrap");

    // Write to the word under the PC: new data only after the edge.
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 8'd0, 32'h5555_5555,
         32'h0, 32'h5555_5555, 32'd11, "write_current");

    adv(32'h4,  32'h2222_2222, 32'd12, "adv_a");
    adv(32'h8,  32'h3333_3333, 32'd13, "adv_b");
    adv(32'hC,  32'h4444_4444, 32'd14, "adv_c");
    adv(32'h10, 32'hA000_0004, 32'd15, "adv_d");
    adv(32'h14, 32'hA000_0005, 32'd16, "adv_e");
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0,
         32'h40, 32'hA000_0010, 32'd17, "branch_40");

    step(1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'd0, 1'b1, 8'd0, 32'hDEAD_BEEF,
         32'h0, 32'hDEAD_BEEF, 32'd0, "reset_wins");
    adv(32'h4, 32'h2222_2222, 32'd1, "retain_w1");
    jmp(32'h40, 32'hA000_0010, 32'd2, "retain_w16");
    hold(32'h40, 32'hA000_0010, 32'd2, "final_hold");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
Fetch stage of the 5-stage pipeline. It sits in front of the IF/ID pipeline register and drives that register's PC+4, instruction and display-PC inputs.
- Holds the program counter and a word-addressed instruction memory.
- Performs sequential fetch.
- Honours hazard-unit stalls and ID-stage branch/jump redirects.
- Provides a program-load port so the bench and top level can preload code.

Parameters:
DEPTH, 256, number of 32-bit instruction words in memory
ADDR_W, 8, word-address width (log2 DEPTH)
RESET_PC, 32'h00000000, PC value after reset

Ports:
Clk  in  1  rising-edge clock
Rst  in  1  synchronous, active-high reset
PCWrite  in  1  hazard unit: 1 = PC may advance, 0 = stall
Branch  in  1  ID-stage branch taken
BranchTarget  in  32  branch destination byte address
jump  in  1  ID-stage jump
JumpTarget  in  32  jump destination byte address
ProgWrite  in  1  program-load write strobe
ProgAddr  in  ADDR_W  program-load word address
ProgData  in  32  program-load word
PC  out  32  current PC; feeds PCDisplay of IF/ID
PCPlus4  out  32  PC+4; feeds PCin of IF/ID
Instruction  out  32  word at PC; feeds InstructionIn of IF/ID
FetchCount  out  32  number of PC updates since reset

Behaviour:
Clocking and reset:
- One clock (Clk). Rst is synchronous and active-high: it is sampled only on a rising Clk edge.
- On a Rst cycle: PC <= RESET_PC and FetchCount <= 0.
- Memory contents are NOT cleared by Rst. ProgWrite is still honoured during a Rst cycle.
- Rst wins over every other PC/counter update in the same cycle.

Next-PC selection at each posedge, priority high to low:
- Rst.
- Branch=1 -> BranchTarget.
- jump=1 -> JumpTarget.
- PCWrite=1 -> PC+4.
- Otherwise hold.

Redirect rules:
- Branch and jump override PCWrite=0, so a redirect issued during a stall is never lost.
- Branch and jump both high is illegal upstream; if it happens, Branch wins.
- Latency: a redirect or advance sampled at edge N makes PC valid with the new value immediately after edge N, one cycle.

FetchCount:
- +1 on every posedge where PC is loaded by Branch, jump or PCWrite.
- Unchanged on a hold.
- Wraps modulo 2^32.

PCPlus4:
- Combinational PC + 32'd4, modulo 2^32.
- PC = 32'hFFFFFFFC gives PCPlus4 = 0. PC itself wraps the same way on sequential advance.

Instruction read:
- Asynchronous/combinational read of mem[PC[ADDR_W+1:2]]. PC[1:0] is ignored; misaligned PCs read the containing word.
- If PC[31:ADDR_W+2] != 0 (outside memory), Instruction = 32'h00000000 (NOP).

Program load:
- On posedge with ProgWrite=1: mem[ProgAddr] <= ProgData.
- The new word is visible on Instruction from the following cycle.
- A write to the word currently addressed shows old data until the edge, new data after it.
- Loading is independent of PCWrite, Branch and jump.

Memory initialisation:
- No reset value.
- The bench must load every word it fetches. Fetching an unloaded word is X.

Test Plan:
- Load words 0..3 = 0x11111111..0x44444444, Rst 1 cycle, then PCWrite=1 for 4 cycles -> PC 0,4,8,12; Instruction tracks the loaded words; PCPlus4 = PC+4; FetchCount = 4.
- At PC=8, drop PCWrite for 3 cycles -> PC, Instruction and FetchCount held (PC=8) for 3 cycles; resumes to 12 on the first edge with PCWrite=1.
- PCWrite=0 with Branch=1, BranchTarget=0x40 -> PC=0x40 after the edge, FetchCount+1. Then jump=1, JumpTarget=0x20 -> PC=0x20. Branch=jump=1 with targets 0x10/0x30 -> PC=0x10.
- Jump to 0x00000400 with DEPTH=256 (outside memory) -> Instruction=0. Jump to 0x0000000A -> reads word 2 (0x33333333).
- Jump to 0xFFFFFFFC then PCWrite=1 -> PCPlus4=0 before the edge; PC=0 after it.
- Mid-run (PC=0x40, FetchCount=17) assert Rst together with Branch=1 and a ProgWrite to word 0 of 0xDEADBEEF -> PC=0, FetchCount=0, Instruction=0xDEADBEEF on the next cycle; other words retain their loaded values.
